medidor_tempo: RTL and testbench

Measures how long the player holds a key, in metronome half-beats, and turns that into beat-count values for the rhythm comparison stage. It is the producing end of the tempo check: its `tempo`, `tempo_baixo` and `meio_metro` outputs drive the tempo comparator, which checks them against the duration stored in note memory. It sits in the datapath between the key synchronizer/metronome and the comparator, and is armed by the game control unit once per note.

---
 rtl/medidor_tempo_if.sv | 23 ++
 rtl/medidor_tempo.sv | 151 +++++++++++++++
 tb/tb_medidor_tempo.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/medidor_tempo_if.sv
// Key-hold duration measurement bus: arm/key/metronome inputs and beat-count results.
interface medidor_tempo_if;
  logic       iniciar;
  logic       tecla_ativa;
  logic       metro_tick;
  logic [3:0] tempo;
  logic [3:0] tempo_baixo;
  logic       meio_metro;
  logic       estouro;
  logic       medindo;
  logic       medida_pronta;
  logic       timeout;

  modport master (
    output iniciar, tecla_ativa, metro_tick,
    input  tempo, tempo_baixo, meio_metro, estouro, medindo, medida_pronta, timeout
  );

  modport slave (
    input  iniciar, tecla_ativa, metro_tick,
    output tempo, tempo_baixo, meio_metro, estouro, medindo, medida_pronta, timeout
  );
endinterface

// File: rtl/medidor_tempo.sv
// Measures key-hold time in metronome half-beats and produces beat counts for the tempo comparator.
// Optional ESPERA timeout enabled by defining MEDIDOR_TIMEOUT_EN.
module medidor_tempo #(
  parameter int unsigned TIMEOUT_MEIOS = 16
) (
  input logic            clock,
  input logic            reset,
  medidor_tempo_if.slave bus
);

  localparam int unsigned H_W    = 5;
  localparam int unsigned CNT_W  = 8;
  localparam logic [H_W-1:0]   H_MAX  = 5'd29;
  localparam logic [CNT_W-1:0] TO_LIM = 8'(TIMEOUT_MEIOS);

  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] ESPERA  = 2'd1;
  localparam logic [1:0] MEDINDO = 2'd2;
  localparam logic [1:0] PRONTO  = 2'd3;

  logic [1:0]     state, state_nxt;
  logic [H_W-1:0] h, h_nxt;
  logic           tecla_d;
  logic [3:0]     tempo_r, tempo_nxt;
  logic [3:0]     baixo_r, baixo_nxt;
  logic           meio_r, meio_nxt;
  logic           estouro_r, estouro_nxt;
  logic           medindo_r, medindo_nxt;
  logic           pronta_r, pronta_nxt;
  logic           press_c;

`ifdef MEDIDOR_TIMEOUT_EN
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             timeout_r, timeout_nxt;
`endif

  assign press_c = bus.tecla_ativa & ~tecla_d;

  // Next-state and next-output decode; iniciar overrides every state
  always_comb begin
    state_nxt   = state;
    h_nxt       = h;
    tempo_nxt   = tempo_r;
    baixo_nxt   = baixo_r;
    meio_nxt    = meio_r;
    estouro_nxt = estouro_r;
`ifdef MEDIDOR_TIMEOUT_EN
    cnt_nxt     = cnt;
    timeout_nxt = 1'b0;
`endif
    if (bus.iniciar) begin
      state_nxt   = ESPERA;
      h_nxt       = '0;
      tempo_nxt   = '0;
      baixo_nxt   = '0;
      meio_nxt    = 1'b0;
      estouro_nxt = 1'b0;
`ifdef MEDIDOR_TIMEOUT_EN
      cnt_nxt     = '0;
`endif
    end else begin
      case (state)
        ESPERA: begin
          if (press_c) begin
            state_nxt = MEDINDO;
            h_nxt     = '0;
          end
`ifdef MEDIDOR_TIMEOUT_EN
          else if (bus.metro_tick) begin
            if ((9'(cnt) + 9'd1) >= 9'(TO_LIM)) begin
              state_nxt   = OCIOSO;
              timeout_nxt = 1'b1;
              cnt_nxt     = '0;
            end else begin
              cnt_nxt = 8'(cnt + 8'd1);
            end
          end
`endif
        end
        MEDINDO: begin
          if (bus.tecla_ativa) begin
            if (bus.metro_tick) begin
              if (h == H_MAX) estouro_nxt = 1'b1;
              else            h_nxt       = 5'(h + 5'd1);
            end
          end else begin
            // Release: latch the beat values; a tick in this cycle is dropped
            tempo_nxt = h[4:1] + 4'd1;
            baixo_nxt = h[4:1];
            meio_nxt  = h[0];
            state_nxt = PRONTO;
          end
        end
        PRONTO:  state_nxt = OCIOSO;
        default: state_nxt = OCIOSO;
      endcase
    end
    medindo_nxt = (state_nxt == MEDINDO);
    pronta_nxt  = (state_nxt == PRONTO);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= OCIOSO;
      h         <= '0;
      tecla_d   <= 1'b0;
      tempo_r   <= '0;
      baixo_r   <= '0;
      meio_r    <= 1'b0;
      estouro_r <= 1'b0;
      medindo_r <= 1'b0;
      pronta_r  <= 1'b0;
    end else begin
      state     <= state_nxt;
      h         <= h_nxt;
      tecla_d   <= bus.tecla_ativa;
      tempo_r   <= tempo_nxt;
      baixo_r   <= baixo_nxt;
      meio_r    <= meio_nxt;
      estouro_r <= estouro_nxt;
      medindo_r <= medindo_nxt;
      pronta_r  <= pronta_nxt;
    end
  end

`ifdef MEDIDOR_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt       <= '0;
      timeout_r <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      timeout_r <= timeout_nxt;
    end
  end

  assign bus.timeout = timeout_r;
`else
  logic unused_cfg;
  assign unused_cfg  = ^TO_LIM;
  assign bus.timeout = 1'b0;
`endif

  assign bus.tempo         = tempo_r;
  assign bus.tempo_baixo   = baixo_r;
  assign bus.meio_metro    = meio_r;
  assign bus.estouro       = estouro_r;
  assign bus.medindo       = medindo_r;
  assign bus.medida_pronta = pronta_r;

endmodule

// File: tb/tb_medidor_tempo.sv
// Self-checking bench for medidor_tempo: directed scenarios plus randomized hold lengths against a beat model.
module tb_medidor_tempo;
  localparam int unsigned TIMEOUT_MEIOS = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  medidor_tempo_if bus ();

  medidor_tempo #(.TIMEOUT_MEIOS(TIMEOUT_MEIOS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic ini, input logic tec, input logic tick);
    bus.iniciar     = ini;
    bus.tecla_ativa = tec;
    bus.metro_tick  = tick;
  endtask

  task automatic arm();
    drive(1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0);
  endtask

  // Beat model: n counted half-beats, saturating at 29
  function automatic logic [11:0] model(input int n);
    int s;
    logic [3:0] t, b;
    logic m, e;
    s = (n > 29) ? 29 : n;
    t = 4'(s / 2 + 1);
    b = 4'(s / 2);
    m = ((s % 2) == 1);
    e = (n > 29);
    // {pronta, medindo, tempo, tempo_baixo, meio, estouro}
    return {1'b1, 1'b0, t, b, m, e};
  endfunction

  function automatic logic [11:0] observed();
    return {bus.medida_pronta, bus.medindo, bus.tempo, bus.tempo_baixo, bus.meio_metro, bus.estouro};
  endfunction

  // Press, n counted ticks with random gaps, release; block must be in ESPERA with key up
  task automatic run_measure(input int n, input int gap_max, input string tag);
    logic [11:0] exp_v, got;
    int g;
    exp_v = model(n);
    drive(1'b0, 1'b1, 1'($urandom % 2));
    step();
    checks++;
    if (bus.medindo !== 1'b1 || bus.medida_pronta !== 1'b0) begin
      errors++;
      $display("FAIL %s press: medindo=%0b pronta=%0b, want medindo=1 pronta=0", tag, bus.medindo, bus.medida_pronta);
    end
    for (int i = 0; i < n; i++) begin
      g = int'($urandom_range(gap_max, 0));
      repeat (g) begin drive(1'b0, 1'b1, 1'b0); step(); end
      drive(1'b0, 1'b1, 1'b1);
      step();
    end
    checks++;
    if (bus.medindo !== 1'b1 || bus.medida_pronta !== 1'b0) begin
      errors++;
      $display("FAIL %s hold: medindo=%0b pronta=%0b, want medindo=1 pronta=0", tag, bus.medindo, bus.medida_pronta);
    end
    drive(1'b0, 1'b0, 1'($urandom % 2));
    step();
    got = observed();
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s result n=%0d: got {pronta,medindo,tempo,baixo,meio,estouro}=%h, want %h", tag, n, got, exp_v);
    end
    drive(1'b0, 1'b0, 1'b0);
    step();
    exp_v[11] = 1'b0;
    got = observed();
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s hold-after: got %h, want %h", tag, got, exp_v);
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    step();
    checks++;
    if ({observed(), bus.timeout} !== 13'd0) begin
      errors++;
      $display("FAIL reset: got outputs %h, want 0", {observed(), bus.timeout});
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    arm();
    run_measure(4, 0, "four_ticks");
    arm();
    run_measure(5, 1, "five_ticks");
    arm();
    run_measure(0, 0, "zero_ticks");
  endtask

  task automatic test_pre_held();
    logic bad;
    bad = 1'b0;
    drive(1'b0, 1'b1, 1'b0);
    step();
    drive(1'b1, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1); step();
      if (bus.medindo !== 1'b0) bad = 1'b1;
      drive(1'b0, 1'b1, 1'b0); step();
      if (bus.medindo !== 1'b0) bad = 1'b1;
    end
    drive(1'b0, 1'b0, 1'b0);
    step();
    if (bus.medida_pronta !== 1'b0 || bus.medindo !== 1'b0) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL pre_held: medindo/pronta seen high while armed key was held, want 0");
    end
    run_measure(2, 1, "re_press");
  endtask

  task automatic test_saturation();
    arm();
    run_measure(40, 0, "saturate");
    arm();
    checks++;
    if (observed() !== 12'd0) begin
      errors++;
      $display("FAIL clear_after_sat: got %h, want 0", observed());
    end
  endtask

  task automatic test_abort();
    arm();
    drive(1'b0, 1'b1, 1'b0);
    step();
    repeat (6) begin drive(1'b0, 1'b1, 1'b1); step(); end
    drive(1'b1, 1'b1, 1'b0);
    step();
    checks++;
    if (observed() !== 12'd0) begin
      errors++;
      $display("FAIL abort_clear: got %h, want 0", observed());
    end
    drive(1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if (bus.medida_pronta !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_pronta: pronta=%0b, want 0", bus.medida_pronta);
    end
    run_measure(1, 0, "after_abort");
  endtask

  task automatic test_back_to_back();
    // iniciar together with the release wins
    arm();
    drive(1'b0, 1'b1, 1'b0);
    step();
    repeat (3) begin drive(1'b0, 1'b1, 1'b1); step(); end
    drive(1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if (observed() !== 12'd0) begin
      errors++;
      $display("FAIL iniciar_vs_release: got %h, want 0", observed());
    end
    drive(1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if (bus.medida_pronta !== 1'b0) begin
      errors++;
      $display("FAIL iniciar_vs_release_late: pronta=%0b, want 0", bus.medida_pronta);
    end
    // iniciar during PRONTO re-arms straight into ESPERA
    drive(1'b0, 1'b1, 1'b0);
    step();
    repeat (2) begin drive(1'b0, 1'b1, 1'b1); step(); end
    drive(1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if (bus.medida_pronta !== 1'b1 || bus.tempo !== 4'd2) begin
      errors++;
      $display("FAIL pronta_before_rearm: pronta=%0b tempo=%0d, want pronta=1 tempo=2", bus.medida_pronta, bus.tempo);
    end
    drive(1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if (observed() !== 12'd0) begin
      errors++;
      $display("FAIL rearm_in_pronta: got %h, want 0", observed());
    end
    drive(1'b0, 1'b0, 1'b0);
    run_measure(3, 0, "after_rearm");
  endtask

  task automatic test_timeout();
    logic bad;
    bad = 1'b0;
`ifdef MEDIDOR_TIMEOUT_EN
    arm();
    for (int i = 0; i < int'(TIMEOUT_MEIOS); i++) begin
      drive(1'b0, 1'b0, 1'b0); step();
      if (bus.timeout !== 1'b0) bad = 1'b1;
      drive(1'b0, 1'b0, 1'b1); step();
      if (i < int'(TIMEOUT_MEIOS) - 1 && bus.timeout !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || bus.timeout !== 1'b1 || bus.medida_pronta !== 1'b0 || bus.tempo !== 4'd0) begin
      errors++;
      $display("FAIL timeout_pulse: timeout=%0b early=%0b pronta=%0b tempo=%0d, want 1 0 0 0",
               bus.timeout, bad, bus.medida_pronta, bus.tempo);
    end
    drive(1'b0, 1'b1, 1'b0);
    step();
    checks++;
    if (bus.timeout !== 1'b0 || bus.medindo !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: timeout=%0b medindo=%0b, want 0 0", bus.timeout, bus.medindo);
    end
    drive(1'b0, 1'b0, 1'b0);
    step();
    arm();
    repeat (int'(TIMEOUT_MEIOS) - 1) begin drive(1'b0, 1'b0, 1'b1); step(); end
    drive(1'b0, 1'b1, 1'b1);
    step();
    checks++;
    if (bus.timeout !== 1'b0 || bus.medindo !== 1'b1) begin
      errors++;
      $display("FAIL press_beats_timeout: timeout=%0b medindo=%0b, want 0 1", bus.timeout, bus.medindo);
    end
    drive(1'b0, 1'b0, 1'b0);
    step();
    step();
`else
    arm();
    repeat (20) begin
      drive(1'b0, 1'b0, 1'b1); step();
      if (bus.timeout !== 1'b0 || bus.medindo !== 1'b0) bad = 1'b1;
      drive(1'b0, 1'b0, 1'b0); step();
      if (bus.timeout !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL no_timeout: timeout or medindo rose while waiting, want 0");
    end
    run_measure(2, 0, "late_press");
`endif
  endtask

  task automatic test_reset_mid();
    arm();
    drive(1'b0, 1'b1, 1'b0);
    step();
    repeat (5) begin drive(1'b0, 1'b1, 1'b1); step(); end
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b1);
    step();
    checks++;
    if ({observed(), bus.timeout} !== 13'd0) begin
      errors++;
      $display("FAIL reset_mid: got %h, want 0", {observed(), bus.timeout});
    end
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0);
    step();
    step();
    checks++;
    if (bus.medida_pronta !== 1'b0 || bus.medindo !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release: pronta=%0b medindo=%0b, want 0 0", bus.medida_pronta, bus.medindo);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      arm();
      checks++;
      if (observed() !== 12'd0) begin
        errors++;
        $display("FAIL rand_arm %0d: got %h, want 0", k, observed());
      end
      repeat ($urandom_range(3, 0)) begin drive(1'b0, 1'b0, 1'b0); step(); end
      run_measure(int'($urandom_range(35, 0)), 2, "random");
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0);
    test_reset();
    test_basic();
    test_pre_held();
    test_saturation();
    test_abort();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
